// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage data-memory responder.
// Owns a single-port synchronous word RAM without byte enables. Loads take
// two stall cycles and return the addressed lane right-aligned and
// zero-extended. Sub-word stores are done as read-modify-write. Word stores
// are written in the same cycle they are seen. Lanes are big-endian.
//
// Handshake: the MEM stage presents a request (mem_read / mem_write with
// address, size, data_write) and must hold it unchanged for as long as
// stall=1. The request is complete in the first cycle it is seen with
// stall=0. The pipeline advances at the end of that cycle. A misaligned
// request completes immediately with misalign=1 and has no other effect.
module dmem_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] data_write,
  input  logic [1:0]  size,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] data_mem,
  output logic        stall,
  output logic        misalign,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    MERGE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DEPTH = 2 ** ADDR_W;

  state_t state;

  // RAM storage and its registered read port.
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] ram_q;

  // Request decode.
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_off;
  logic              is_word;
  logic              is_half;
  logic              is_byte;
  logic              is_store;
  logic              req;
  logic              addr_bad;
  logic              accept;
  logic              word_store_now;

  // Lane shifting.
  logic [4:0]        byte_shift;
  logic [4:0]        half_shift;
  logic [31:0]       lane_mask;
  logic [31:0]       lane_data;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;

  // RAM port controls.
  logic              ram_we;
  logic              ram_re;
  logic [31:0]       ram_wdata;

  // Address bits above the RAM depth are ignored, so accesses wrap.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^address[31:ADDR_W+2];

  assign word_idx = address[ADDR_W+1:2];
  assign byte_off = address[1:0];

  // Decode the request. Size 11 is handled as a word. A request with both
  // read and write set is a store.
  always_comb begin
    is_word  = (size == 2'b00) || (size == 2'b11);
    is_half  = (size == 2'b01);
    is_byte  = (size == 2'b10);
    is_store = mem_write;
    req      = mem_write || mem_read;
    addr_bad = (is_half && byte_off[0]) || (is_word && (byte_off != 2'b00));
  end

  // Accept aligned requests only in IDLE and outside reset.
  always_comb begin
    accept         = !rst && (state == IDLE) && req && !addr_bad;
    word_store_now = accept && is_store && is_word;
    misalign       = !rst && (state == IDLE) && req && addr_bad;
    stall          = !rst && ((accept && !word_store_now) ||
                              (state == RD) || (state == RMW_RD));
  end

  // Big-endian lane positions. Byte offset 0 sits at bits [31:24], which
  // gives a shift of 8*(3-off). Halfword offset 0 sits at bits [31:16].
  always_comb begin
    byte_shift = {~byte_off, 3'b000};
    half_shift = {~byte_off[1], 4'b0000};
    lane_mask  = 32'h0000_0000;
    lane_data  = 32'h0000_0000;
    if (is_byte) begin
      lane_mask = 32'h0000_00ff << byte_shift;
      lane_data = {24'h00_0000, data_write[7:0]} << byte_shift;
    end else if (is_half) begin
      lane_mask = 32'h0000_ffff << half_shift;
      lane_data = {16'h0000, data_write[15:0]} << half_shift;
    end else begin
      lane_mask = 32'hffff_ffff;
      lane_data = data_write;
    end
  end

  // Right-align the addressed lane of the RAM word for loads, and splice
  // the store lane into the old word for read-modify-write.
  always_comb begin
    load_data = ram_q;
    if (is_byte) begin
      load_data = (ram_q >> byte_shift) & 32'h0000_00ff;
    end else if (is_half) begin
      load_data = (ram_q >> half_shift) & 32'h0000_ffff;
    end
    merged_word = (ram_q & ~lane_mask) | lane_data;
  end

  // RAM port arbitration. One access per cycle. The merge write is dropped
  // when reset is asserted on that edge.
  always_comb begin
    ram_we    = word_store_now || ((state == MERGE) && !rst);
    ram_re    = accept && !word_store_now;
    ram_wdata = word_store_now ? data_write : merged_word;
  end

  // Single-port synchronous RAM. The read register holds its value when no
  // read is issued, so the old word stays visible through MERGE.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[word_idx] <= ram_wdata;
    end else if (ram_re) begin
      ram_q <= mem[word_idx];
    end
  end

  // Access sequencer. data_mem is loaded only when a load finishes in RD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_mem <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !word_store_now) begin
            state <= is_store ? RMW_RD : RD;
          end
        end
        RD: begin
          data_mem <= load_data;
          state    <= DONE;
        end
        RMW_RD: state <= MERGE;
        MERGE:  state <= IDLE;
        DONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed requests with hand-computed
// expected stall counts, misalign flags and data_mem values.
module tb_dmem_ctrl;

  localparam int ADDR_W = 10;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic [31:0] data_write;
  logic [1:0]  size;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] data_mem;
  logic        stall;
  logic        misalign;
  logic [2:0]  dbg_state;

  // {misalign, stall cycles[1:0], data_mem after completion}
  logic [34:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en = 1'b1;

  localparam logic [1:0] SZ_W  = 2'b00;
  localparam logic [1:0] SZ_H  = 2'b01;
  localparam logic [1:0] SZ_B  = 2'b10;
  localparam logic [1:0] SZ_W3 = 2'b11;

  dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .data_write (data_write),
    .size       (size),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .data_mem   (data_mem),
    .stall      (stall),
    .misalign   (misalign),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    address    = 32'h0;
    data_write = 32'h0;
    size       = SZ_W;
  endtask

  // Driver: present one request, push its expectation, and hold it until
  // the cycle it completes (stall=0); release after that clock edge.
  task automatic do_req(input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic wr, input logic rd,
                        input logic mis, input int stalls,
                        input logic [31:0] dm);
    logic done;
    exp_q.push_back({mis, 2'(stalls), dm});
    address    = a;
    data_write = wd;
    size       = sz;
    mem_write  = wr;
    mem_read   = rd;
    done       = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: addr %h still stalled after 8 cycles", a);
    end
    @(posedge clk);
    #1;
    clear_req();
  endtask

  // Monitor: counts stall cycles of the live request and, when it completes,
  // compares against the next expectation.
  initial begin
    int stall_run;
    logic [34:0] e;
    stall_run = 0;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && (mem_read || mem_write)) begin
        if (stall) begin
          stall_run++;
        end else begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_completion: addr %h with no expectation",
                     address);
          end else begin
            e = exp_q.pop_front();
            check("stall_cycles", 32'(stall_run), {30'h0, e[33:32]});
            check("misalign", {31'h0, misalign}, {31'h0, e[34]});
            check("data_mem", data_mem, e[31:0]);
          end
          stall_run = 0;
        end
      end
    end
  end

  // Stimulus.
  initial begin
    rst = 1'b1;
    clear_req();
    repeat (3) @(posedge clk);
    // A misaligned load held during reset must not raise flags.
    #1;
    address  = 32'h13;
    size     = SZ_H;
    mem_read = 1'b1;
    @(negedge clk);
    check("rst_data_mem", data_mem, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_misalign", {31'h0, misalign}, 32'h0);
    check("rst_state", {29'h0, dbg_state}, 32'h0);
    @(posedge clk);
    #1;
    clear_req();
    rst = 1'b0;
    @(posedge clk);
    #1;

    //     addr          wdata         size   wr    rd    mis   st data_mem
    do_req(32'h10,   32'hDEADBEEF, SZ_W,  1'b1, 1'b0, 1'b0, 0, 32'h0);
    do_req(32'h10,   32'h0,        SZ_W,  1'b0, 1'b1, 1'b0, 2, 32'hDEADBEEF);
    do_req(32'h11,   32'hFFFFFF5A, SZ_B,  1'b1, 1'b0, 1'b0, 2, 32'hDEADBEEF);
    do_req(32'h10,   32'h0,        SZ_W,  1'b0, 1'b1, 1'b0, 2, 32'hDE5ABEEF);
    do_req(32'h12,   32'h0,        SZ_H,  1'b0, 1'b1, 1'b0, 2, 32'h0000BEEF);
    do_req(32'h10,   32'h0,        SZ_B,  1'b0, 1'b1, 1'b0, 2, 32'h000000DE);
    do_req(32'h13,   32'h0,        SZ_H,  1'b0, 1'b1, 1'b1, 0, 32'h000000DE);
    do_req(32'h12,   32'h12345678, SZ_W,  1'b1, 1'b0, 1'b1, 0, 32'h000000DE);
    do_req(32'h10,   32'h0,        SZ_W,  1'b0, 1'b1, 1'b0, 2, 32'hDE5ABEEF);
    do_req(32'h12,   32'h1234CAFE, SZ_H,  1'b1, 1'b0, 1'b0, 2, 32'hDE5ABEEF);
    do_req(32'h10,   32'h0,        SZ_H,  1'b0, 1'b1, 1'b0, 2, 32'h0000DE5A);
    do_req(32'h10,   32'h0,        SZ_W,  1'b0, 1'b1, 1'b0, 2, 32'hDE5ACAFE);
    // Store with read also high behaves as a store.
    do_req(32'h13,   32'h00000077, SZ_B,  1'b1, 1'b1, 1'b0, 2, 32'hDE5ACAFE);
    do_req(32'h13,   32'h0,        SZ_B,  1'b0, 1'b1, 1'b0, 2, 32'h00000077);
    do_req(32'h10,   32'h0,        SZ_W3, 1'b0, 1'b1, 1'b0, 2, 32'hDE5ACA77);
    do_req(32'h14,   32'h01020304, SZ_W,  1'b1, 1'b1, 1'b0, 0, 32'hDE5ACA77);
    do_req(32'h14,   32'h0,        SZ_W,  1'b0, 1'b1, 1'b0, 2, 32'h01020304);
    // Aliasing: 0x10 + 4*2^ADDR_W maps onto word 0x10.
    do_req(32'h1010, 32'h0,        SZ_W,  1'b0, 1'b1, 1'b0, 2, 32'hDE5ACA77);
    do_req(32'h1014, 32'hA5A5A5A5, SZ_W,  1'b1, 1'b0, 1'b0, 0, 32'hDE5ACA77);
    do_req(32'h14,   32'h0,        SZ_W,  1'b0, 1'b1, 1'b0, 2, 32'hA5A5A5A5);
    do_req(32'h11,   32'h0,        SZ_B,  1'b0, 1'b1, 1'b0, 2, 32'h0000005A);
    do_req(32'h12,   32'h0,        SZ_B,  1'b0, 1'b1, 1'b0, 2, 32'h000000CA);
    do_req(32'h20,   32'h11223344, SZ_W,  1'b1, 1'b0, 1'b0, 0, 32'h000000CA);

    // Reset asserted in MERGE: the merge write is suppressed.
    mon_en     = 1'b0;
    address    = 32'h21;
    data_write = 32'h000000AA;
    size       = SZ_B;
    mem_write  = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("merge_state", {29'h0, dbg_state}, 32'd3);
    check("merge_stall", {31'h0, stall}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_req();
    check("post_rst_state", {29'h0, dbg_state}, 32'h0);
    check("post_rst_data_mem", data_mem, 32'h0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    do_req(32'h20,   32'h0,        SZ_W,  1'b0, 1'b1, 1'b0, 2, 32'h11223344);

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
